// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing around the decoder: EX/MEM destination tracking, pause code
// generation, stall/flush/bubble control and a dmem ready/ack freeze with timeout.
module pipeline_hazard_ctrl #(
   parameter int          FORWARD     = 1,
   parameter int          DELAY_SLOT  = 1,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_wr_en,
   input  logic [4:0] id_wr_reg,
   input  logic       id_is_load,
   input  logic       id_is_mem,
   input  logic       stall_in,
   input  logic       pc_redirect,
   input  logic       dmem_ack,
   output logic [1:0] pause_code,
   output logic       if_en,
   output logic       id_en,
   output logic       ex_en,
   output logic       mem_en,
   output logic       id_bubble,
   output logic       if_flush,
   output logic       dmem_req,
   output logic       mem_err
);

   localparam int CW = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic          r_mem_err, w_err_set;
   logic          w_freeze;

   logic          r_ex_valid, r_ex_load, r_ex_mem;
   logic [4:0]    r_ex_reg;
   logic          r_mem_valid, r_mem_mem;
   logic [4:0]    r_mem_reg;

   logic          w_ex_hz, w_mem_hz, w_rs_hit, w_rt_hit;
   logic          w_mem_access;

   // valid marks a register write; stores have no destination yet still access
   // memory, so is_mem carries its own bubble qualification.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex_valid  <= 1'b0;
         r_ex_reg    <= '0;
         r_ex_load   <= 1'b0;
         r_ex_mem    <= 1'b0;
         r_mem_valid <= 1'b0;
         r_mem_reg   <= '0;
         r_mem_mem   <= 1'b0;
      end else begin
         if (ex_en) begin
            r_ex_valid <= id_wr_en & ~stall_in & ~id_bubble;
            r_ex_reg   <= id_wr_reg;
            r_ex_load  <= id_is_load;
            r_ex_mem   <= id_is_mem & ~stall_in & ~id_bubble;
         end
         if (mem_en) begin
            r_mem_valid <= r_ex_valid;
            r_mem_reg   <= r_ex_reg;
            r_mem_mem   <= r_ex_mem;
         end
      end
   end

   always_comb begin
      w_ex_hz    = r_ex_valid & ((FORWARD == 0) | r_ex_load);
      w_mem_hz   = (FORWARD == 0) & r_mem_valid;
      w_rs_hit   = (id_rs != 5'd0) &
                   ((w_ex_hz & (r_ex_reg == id_rs)) | (w_mem_hz & (r_mem_reg == id_rs)));
      w_rt_hit   = (id_rt != 5'd0) &
                   ((w_ex_hz & (r_ex_reg == id_rt)) | (w_mem_hz & (r_mem_reg == id_rt)));
      pause_code = {w_rt_hit, w_rs_hit};
   end

   assign w_mem_access = r_mem_mem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_RUN;
         r_cnt     <= '0;
         r_mem_err <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_err_set)
            r_mem_err <= 1'b1;
      end
   end

   // The freeze starts in the request cycle so the access stays parked in MEM.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_err_set   = 1'b0;
      w_freeze    = 1'b0;
      dmem_req    = 1'b0;
      if_en       = 1'b1;
      id_en       = 1'b1;
      ex_en       = 1'b1;
      mem_en      = 1'b1;
      id_bubble   = 1'b0;
      if_flush    = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (w_mem_access) begin
               dmem_req = 1'b1;
               if (!dmem_ack) begin
                  w_freeze    = 1'b1;
                  w_state_nxt = ST_WAIT;
                  w_cnt_nxt   = r_cnt + CW'(1);
               end
            end
            if (!w_freeze) begin
               if (stall_in) begin
                  if_en     = 1'b0;
                  id_en     = 1'b0;
                  id_bubble = 1'b1;
               end else if (pc_redirect && (DELAY_SLOT == 0)) begin
                  if_flush = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            dmem_req = 1'b1;
            if (dmem_ack) begin
               w_state_nxt = ST_RUN;
               w_cnt_nxt   = '0;
            end else if (r_cnt >= CNT_LAST) begin
               w_freeze    = 1'b1;
               w_state_nxt = ST_ERR;
               w_cnt_nxt   = '0;
               w_err_set   = 1'b1;
            end else begin
               w_freeze  = 1'b1;
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         ST_ERR: begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
         end
         default: begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
         end
      endcase
      if (w_freeze) begin
         if_en  = 1'b0;
         id_en  = 1'b0;
         ex_en  = 1'b0;
         mem_en = 1'b0;
      end
   end

   assign mem_err = r_mem_err;

endmodule
